game_memory_port_sched: RTL and testbench

Scheduler for the FPGA-side port (port b) of the dual-port game memory: 256 words of 32 bits, with port a owned by the processor. It shares that single port between two FPGA requesters (requester 0: game logic, read/write; requester 1: display renderer, read/write) using round-robin grants. It also contains a board-clear engine that overwrites every word with a fill value. It sits between the FPGA game logic and the `Q_address`/`Q_wren`/`Q_input_data`/`Q_export` conduit of the memory interface.

---
 rtl/game_memory_port_sched.sv | 189 ++++++++++++++++++
 tb/tb_game_memory_port_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_memory_port_sched.sv
// game_memory_port_sched: shares memory port b between the game logic (0)
// and the display renderer (1) with round-robin grants, and owns a
// board-clear engine that sweeps a fill value over every word.
module game_memory_port_sched #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Counter is one bit wider so "all words issued" is a distinct value.
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_END = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                last1_q, last1_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   clr_val_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wren_q, wren_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [RD_LATENCY:0] pvld_q;
    logic [RD_LATENCY:0] pid_q;
    logic                rd_issue;
    logic                rd_id;
    logic                rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    // Next-state, arbitration and memory-bus selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last1_d  = last1_q;
        done_d   = 1'b0;
        addr_d   = addr_q;
        wren_d   = 1'b0;
        wdata_d  = wdata_q;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rd_issue = 1'b0;
        rd_id    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    // Address 0 goes on the bus right away; the counter
                    // then tracks the next address to issue.
                    state_d = ST_CLEAR;
                    cnt_d   = CNT_ONE;
                    addr_d  = '0;
                    wren_d  = 1'b1;
                    wdata_d = clear_value;
                end else if (!reset) begin
                    // On a tie the requester that did not win last time wins.
                    gnt0 = req0 && (!req1 || last1_q);
                    gnt1 = req1 && (!req0 || !last1_q);
                    if (gnt0) begin
                        addr_d   = addr0;
                        wren_d   = we0;
                        wdata_d  = wdata0;
                        last1_d  = 1'b0;
                        rd_issue = !we0;
                        rd_id    = 1'b0;
                    end else if (gnt1) begin
                        addr_d   = addr1;
                        wren_d   = we1;
                        wdata_d  = wdata1;
                        last1_d  = 1'b1;
                        rd_issue = !we1;
                        rd_id    = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_END) begin
                    // Last word is on the bus this cycle; finish next cycle.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wren_d  = 1'b1;
                    wdata_d = clr_val_q;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, round-robin pointer and registered memory bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last1_q <= 1'b1;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last1_q <= last1_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
        end
    end

    // Fill word is captured when a clear is accepted.
    always_ff @(posedge clock) begin
        if (state_q == ST_IDLE && clear_start) begin
            clr_val_q <= clear_value;
        end
    end

    // Read tag pipeline: a read issued on the bus reaches the last stage
    // in the same cycle its data appears on mem_rdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pvld_q <= '0;
            pid_q  <= '0;
        end else begin
            pvld_q <= {pvld_q[RD_LATENCY-1:0], rd_issue};
            pid_q  <= {pid_q[RD_LATENCY-1:0], rd_id};
        end
    end

    // Return read data to the requester that issued it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= pvld_q[RD_LATENCY] && !pid_q[RD_LATENCY];
            rvalid1_q <= pvld_q[RD_LATENCY] &&  pid_q[RD_LATENCY];
            if (pvld_q[RD_LATENCY] && !pid_q[RD_LATENCY]) begin
                rdata0_q <= mem_rdata;
            end
            if (pvld_q[RD_LATENCY] && pid_q[RD_LATENCY]) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign clear_busy  = (state_q == ST_CLEAR);
    assign clear_done  = done_q;
    assign mem_address = addr_q;
    assign mem_wren    = wren_q;
    assign mem_wdata   = wdata_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_game_memory_port_sched.sv
// Bench for game_memory_port_sched: memory model on port b, transaction
// level reference model checked every cycle, directed and random stimulus.
module tb_game_memory_port_sched;

    localparam int LAT = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        clear_start = 1'b0;
    logic [31:0] clear_value = '0;
    logic        clear_busy, clear_done;
    logic [7:0]  mem_address;
    logic        mem_wren;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        pl_we = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    game_memory_port_sched #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Port-b memory: one-cycle registered read, with a preload path.
    logic [31:0] mem [0:255];
    always @(posedge clock) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_wren) mem[mem_address] <= mem_wdata;
        mem_rdata <= mem[mem_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        id;
    } bus_t;
    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } rv_t;

    bus_t        bus_ev[int];   // expected bus operation keyed by cycle
    rv_t         rv_ev[int];    // expected read return keyed by cycle
    logic [31:0] shadow [0:255];
    int          busy_until = -1;
    int          done_cyc = -1;
    int          last_winner = 1;
    logic [7:0]  exp_addr = '0;
    logic        gseen0 = 1'b0, gseen1 = 1'b0;

    task automatic model_cycle();
        int   winner;
        bit   idle;
        bus_t ev;
        rv_t  r;
        if (pl_we) shadow[pl_addr] = pl_data;
        if (reset) begin
            chk("rst_ctrl", {25'd0, gnt0, gnt1, rvalid0, rvalid1, clear_busy, clear_done, mem_wren}, 32'd0);
            chk("rst_addr", {24'd0, mem_address}, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
            chk("rst_rdata", rdata0 | rdata1, 32'd0);
            bus_ev.delete();
            rv_ev.delete();
            busy_until = -1;
            done_cyc = -1;
            last_winner = 1;
            exp_addr = '0;
            gseen0 = 1'b0;
            gseen1 = 1'b0;
            return;
        end
        idle = (cyc > busy_until);
        winner = -1;
        if (idle && !clear_start) begin
            if (req0 && req1) winner = 1 - last_winner;
            else if (req0) winner = 0;
            else if (req1) winner = 1;
        end
        chk("gnt0", {31'd0, gnt0}, (winner == 0) ? 32'd1 : 32'd0);
        chk("gnt1", {31'd0, gnt1}, (winner == 1) ? 32'd1 : 32'd0);
        chk("busy", {31'd0, clear_busy}, idle ? 32'd0 : 32'd1);
        chk("done", {31'd0, clear_done}, (cyc == done_cyc) ? 32'd1 : 32'd0);
        if (bus_ev.exists(cyc)) begin
            ev = bus_ev[cyc];
            bus_ev.delete(cyc);
            chk("bus_wren", {31'd0, mem_wren}, {31'd0, ev.we});
            chk("bus_addr", {24'd0, mem_address}, {24'd0, ev.addr});
            exp_addr = ev.addr;
            if (ev.we) begin
                chk("bus_wdata", mem_wdata, ev.data);
                shadow[ev.addr] = ev.data;
            end else begin
                r.id = ev.id;
                r.data = shadow[ev.addr];
                rv_ev[cyc + LAT + 1] = r;
            end
        end else begin
            chk("bus_idle_wren", {31'd0, mem_wren}, 32'd0);
            chk("bus_hold_addr", {24'd0, mem_address}, {24'd0, exp_addr});
        end
        if (rv_ev.exists(cyc)) begin
            r = rv_ev[cyc];
            rv_ev.delete(cyc);
            chk("rvalid0", {31'd0, rvalid0}, r.id ? 32'd0 : 32'd1);
            chk("rvalid1", {31'd0, rvalid1}, r.id ? 32'd1 : 32'd0);
            chk("rdata", r.id ? rdata1 : rdata0, r.data);
        end else begin
            chk("rvalid_idle", {30'd0, rvalid0, rvalid1}, 32'd0);
        end
        if (idle && clear_start) begin
            busy_until = cyc + 256;
            done_cyc = cyc + 257;
            for (int i = 0; i < 256; i++) begin
                ev.we = 1'b1;
                ev.addr = i[7:0];
                ev.data = clear_value;
                ev.id = 1'b0;
                bus_ev[cyc + 1 + i] = ev;
            end
        end
        if (winner >= 0) begin
            ev.we   = (winner == 1) ? we1 : we0;
            ev.addr = (winner == 1) ? addr1 : addr0;
            ev.data = (winner == 1) ? wdata1 : wdata0;
            ev.id   = (winner == 1);
            bus_ev[cyc + 1] = ev;
            last_winner = winner;
        end
        gseen0 = gnt0;
        gseen1 = gnt1;
    endtask

    initial begin : model_proc
        forever begin
            @(negedge clock);
            model_cycle();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a transaction, wait for its grant, then withdraw the request.
    task automatic txn(input int n, input logic we, input logic [7:0] a,
                       input logic [31:0] d, output int gc);
        bit got;
        got = 0;
        gc = -1;
        if (n == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int k = 0; k < 600 && !got; k++) begin
            @(negedge clock);
            if ((n == 0 && gnt0) || (n == 1 && gnt1)) begin
                got = 1;
                gc = cyc;
            end
        end
        chk("txn_granted", {31'd0, got}, 32'd1);
        step();
        if (n == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int gc, bad, early, dones, rvc;
        step();
        for (int i = 0; i < 256; i++) begin
            pl_we = 1'b1;
            pl_addr = i[7:0];
            pl_data = (i == 32'h12) ? 32'hDEAD_BEEF : $urandom;
            step();
        end
        pl_we = 1'b0;
        @(negedge clock);
        chk("reset_busy", {31'd0, clear_busy}, 32'd0);
        chk("reset_wren", {31'd0, mem_wren}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("idle_outs", {28'd0, gnt0, gnt1, rvalid0, clear_done}, 32'd0);
        step();

        // Single read by requester 1.
        txn(1, 1'b0, 8'h12, 32'd0, gc);
        @(negedge clock);
        chk("t1_addr", {24'd0, mem_address}, 32'h12);
        chk("t1_rd_not_write", {31'd0, mem_wren}, 32'd0);
        @(negedge clock);
        chk("t1_rv_early", {31'd0, rvalid1}, 32'd0);
        @(negedge clock);
        chk("t1_rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("t1_rdata1", rdata1, 32'hDEAD_BEEF);
        chk("t1_rvalid0", {31'd0, rvalid0}, 32'd0);
        step();

        // Write then read by requester 0.
        txn(0, 1'b1, 8'h05, 32'h0000_00A5, gc);
        txn(0, 1'b0, 8'h05, 32'd0, gc);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("t2_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("t2_rdata0", rdata0, 32'h0000_00A5);
        step();

        // Contention straight after reset.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h21;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h22;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("ct_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("ct_gnt1", {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (5) step();

        // Full clear with requester 0 waiting throughout.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h07;
        clear_start = 1'b1; clear_value = 32'h0000_0003;
        @(negedge clock);
        chk("cl_start_nogrant", {31'd0, gnt0}, 32'd0);
        step();
        clear_start = 1'b0;
        bad = 0; early = 0; dones = 0;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clock);
            if (k <= 256) begin
                if (!(mem_wren === 1'b1 && mem_address === 8'(k - 1) && mem_wdata === 32'h3)) bad++;
                if (gnt0) early++;
            end
            if (clear_done) dones++;
            if (k == 257) begin
                chk("cl_gnt_after", {31'd0, gnt0}, 32'd1);
                chk("cl_busy_end", {31'd0, clear_busy}, 32'd0);
            end
            step();
            clear_start = (k == 50);
            clear_value = 32'hFFFF_FFFF;
        end
        clear_start = 1'b0;
        req0 = 1'b0;
        chk("cl_write_errs", bad, 32'd0);
        chk("cl_early_gnts", early, 32'd0);
        chk("cl_done_pulses", dones, 32'd1);
        repeat (4) step();
        for (int i = 0; i < 256; i++) txn(1, 1'b0, 8'(i), 32'd0, gc);
        @(negedge clock);
        @(negedge clock);
        chk("cl_last_word", rdata1, 32'h0000_0003);
        chk("cl_last_rv", {31'd0, rvalid1}, 32'd1);
        step();

        // Read in flight when a clear starts.
        txn(0, 1'b1, 8'h40, 32'h1234_5678, gc);
        txn(0, 1'b0, 8'h40, 32'd0, gc);
        clear_start = 1'b1;
        clear_value = 32'h5A5A_5A5A;
        rvc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rvalid0) begin
                rvc++;
                chk("if_rdata0", rdata0, 32'h1234_5678);
            end
            step();
            clear_start = (k == 3);
        end
        clear_start = 1'b0;
        chk("if_rv_count", rvc, 32'd1);
        for (int k = 0; k < 400 && clear_busy; k++) step();
        chk("if_clear_ended", {31'd0, clear_busy}, 32'd0);
        step();

        // Asynchronous reset part way through a clear with a read waiting.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'd200;
        clear_start = 1'b1; clear_value = 32'h0000_000A;
        step();
        clear_start = 1'b0;
        repeat (101) step();
        reset = 1'b1;
        #1;
        chk("ar_wren", {31'd0, mem_wren}, 32'd0);
        chk("ar_busy", {31'd0, clear_busy}, 32'd0);
        chk("ar_addr0", {24'd0, mem_address}, 32'd0);
        chk("ar_wdata0", mem_wdata, 32'd0);
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("ar_gnt0", {31'd0, gnt0}, 32'd1);
        step();
        req0 = 1'b0;
        @(negedge clock);
        chk("ar_bus_addr", {24'd0, mem_address}, 32'd200);
        @(negedge clock);
        chk("ar_rv_early", {31'd0, rvalid0}, 32'd0);
        @(negedge clock);
        chk("ar_rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("ar_rdata0", rdata0, 32'h5A5A_5A5A);
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            @(negedge clock);
            if (clear_done) dones++;
        end
        chk("ar_no_done", dones, 32'd0);
        step();

        // Randomized traffic with occasional clears.
        for (int c = 0; c < 3000; c++) begin
            if (req0 && gseen0) req0 = 1'b0;
            if (req1 && gseen1) req1 = 1'b0;
            if (!req0 && $urandom_range(0, 3) != 0) begin
                req0 = 1'b1;
                we0 = 1'($urandom_range(0, 1));
                addr0 = 8'($urandom_range(0, 15));
                wdata0 = $urandom;
            end
            if (!req1 && $urandom_range(0, 3) != 0) begin
                req1 = 1'b1;
                we1 = 1'($urandom_range(0, 1));
                addr1 = 8'($urandom_range(0, 15));
                wdata1 = $urandom;
            end
            clear_start = ($urandom_range(0, 599) == 0);
            clear_value = $urandom;
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        clear_start = 1'b0;
        for (int k = 0; k < 400 && clear_busy; k++) step();
        chk("end_idle", {31'd0, clear_busy}, 32'd0);
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
